// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM chip responder: command encoding, error codes,
// mode register layout and burst-length decode.
package sdram_resp_pkg;

  // {ras_n, cas_n, we_n} with cs_n low; cs_n high always decodes as NOP
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } sdram_cmd_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CLOSED   = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
  localparam logic [2:0] ERR_NO_MODE  = 3'd3;
  localparam logic [2:0] ERR_REF_OPEN = 3'd4;
  localparam logic [2:0] ERR_BAD_MODE = 3'd5;

  localparam int MR_BL_LSB   = 0;
  localparam int MR_BT_BIT   = 3;
  localparam int MR_CL_LSB   = 4;
  localparam int PRE_ALL_BIT = 10;

  localparam logic [2:0] CL_MIN = 3'd2;
  localparam logic [2:0] CL_MAX = 3'd3;

  localparam int PIPE_DEPTH = 3;

  function automatic logic [3:0] bl_decode(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// CAS-latency delay line for read beats; the output tap moves with the programmed CL.
module sdram_rd_pipe
  import sdram_resp_pkg::*;
#(
  parameter int DQ_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    flush,
  input  logic                    hold,
  input  logic                    cl3,
  input  logic                    push_vld,
  input  logic [DQ_WIDTH-1:0]     push_data,
  input  logic [DQ_WIDTH/8-1:0]   push_oe,
  output logic [DQ_WIDTH-1:0]     out_data,
  output logic [DQ_WIDTH/8-1:0]   out_oe
);

  logic [PIPE_DEPTH-1:0]                   vld_q, vld_d;
  logic [PIPE_DEPTH-1:0][DQ_WIDTH-1:0]     data_q, data_d;
  logic [PIPE_DEPTH-1:0][DQ_WIDTH/8-1:0]   oe_q, oe_d;
  logic [1:0]                              tap;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    oe_d   = oe_q;
    if (flush) begin
      vld_d = '0;
    end else if (!hold) begin
      vld_d  = {vld_q[PIPE_DEPTH-2:0], push_vld};
      data_d = {data_q[PIPE_DEPTH-2:0], push_data};
      oe_d   = {oe_q[PIPE_DEPTH-2:0], push_oe};
    end
  end

  always_ff @(posedge clk) begin
    vld_q  <= vld_d;
    data_q <= data_d;
    oe_q   <= oe_d;
  end

  // Stage 0 is loaded on the READ edge, so stage CL-1 lines up with cycle t+CL
  always_comb begin
    tap      = cl3 ? 2'd2 : 2'd1;
    out_data = data_q[tap];
    out_oe   = vld_q[tap] ? oe_q[tap] : '0;
  end

endmodule

// File: rtl/sdram_chip_responder.sv
// Cycle-level SDRAM device model: command decode, per-bank open rows, mode register,
// burst engine over a reduced-depth array, CAS-delayed read drive and error latching.
module sdram_chip_responder
  import sdram_resp_pkg::*;
#(
  parameter int ROW_BITS      = 13,
  parameter int COL_BITS      = 10,
  parameter int BANK_BITS     = 2,
  parameter int DQ_WIDTH      = 32,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [ROW_BITS-1:0]    sdram_addr,
  input  logic [BANK_BITS-1:0]   sdram_ba,
  input  logic                   sdram_cs_n,
  input  logic                   sdram_ras_n,
  input  logic                   sdram_cas_n,
  input  logic                   sdram_we_n,
  input  logic                   sdram_cke,
  inout  wire  [DQ_WIDTH-1:0]    sdram_dq,
  input  logic [DQ_WIDTH/8-1:0]  sdram_dqm,
  output logic                   mode_valid,
  output logic                   err_flag,
  output logic [2:0]             err_code
);

  localparam int NBANK     = 1 << BANK_BITS;
  localparam int NBYTE     = DQ_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

  sdram_cmd_e cmd;

  logic                                mode_valid_q, mode_valid_d;
  logic                                cl3_q, cl3_d;
  logic [1:0]                          bl_code_q, bl_code_d;
  logic [NBANK-1:0]                    bank_open_q, bank_open_d;
  logic [NBANK-1:0][ROW_BITS-1:0]      open_row_q, open_row_d;
  logic                                err_flag_q, err_flag_d;
  logic [2:0]                          err_code_q, err_code_d;
  logic [2:0]                          err_now;

  logic                                bst_act_q, bst_act_d;
  logic                                bst_wr_q, bst_wr_d;
  logic [BANK_BITS-1:0]                bst_ba_q, bst_ba_d;
  logic [ROW_BITS-1:0]                 bst_row_q, bst_row_d;
  logic [COL_BITS-1:0]                 bst_col_q, bst_col_d;
  logic [2:0]                          bst_beat_q, bst_beat_d;

  logic                                rdwr_ok, wr_start;
  logic [2:0]                          bl_mask;
  logic                                beat_go, beat_wr;
  logic [BANK_BITS-1:0]                beat_ba;
  logic [ROW_BITS-1:0]                 beat_row;
  logic [COL_BITS-1:0]                 beat_col, beat_col_eff;
  logic [2:0]                          beat_k, beat_lo;
  logic [MEM_ADDR_BITS-1:0]            mem_idx;
  logic                                mem_we;
  logic [DQ_WIDTH-1:0]                 mem_q [MEM_DEPTH];

  logic                                pipe_flush;
  logic [DQ_WIDTH-1:0]                 rd_data;
  logic [NBYTE-1:0]                    rd_oe;

  always_comb begin
    cmd = CMD_NOP;
    if (sdram_cke && !sdram_cs_n)
      cmd = sdram_cmd_e'({1'b0, sdram_ras_n, sdram_cas_n, sdram_we_n});
  end

  // Mode, bank and error bookkeeping
  always_comb begin
    mode_valid_d = mode_valid_q;
    cl3_d        = cl3_q;
    bl_code_d    = bl_code_q;
    bank_open_d  = bank_open_q;
    open_row_d   = open_row_q;
    err_flag_d   = err_flag_q;
    err_code_d   = err_code_q;
    err_now      = ERR_NONE;
    case (cmd)
      CMD_LMR: begin
        if (sdram_addr[MR_BL_LSB +: 3] <= 3'd3 && !sdram_addr[MR_BT_BIT] &&
            (sdram_addr[MR_CL_LSB +: 3] == CL_MIN || sdram_addr[MR_CL_LSB +: 3] == CL_MAX)) begin
          mode_valid_d = 1'b1;
          cl3_d        = (sdram_addr[MR_CL_LSB +: 3] == CL_MAX);
          bl_code_d    = sdram_addr[MR_BL_LSB +: 2];
        end else begin
          err_now = ERR_BAD_MODE;
        end
      end
      CMD_ACT: begin
        if (bank_open_q[sdram_ba]) err_now = ERR_ACT_OPEN;
        bank_open_d[sdram_ba] = 1'b1;
        open_row_d[sdram_ba]  = sdram_addr;
      end
      CMD_PRE: begin
        if (sdram_addr[PRE_ALL_BIT]) bank_open_d = '0;
        else                         bank_open_d[sdram_ba] = 1'b0;
      end
      CMD_REF: if (|bank_open_q) err_now = ERR_REF_OPEN;
      CMD_RD, CMD_WR: begin
        if (!mode_valid_q)                err_now = ERR_NO_MODE;
        else if (!bank_open_q[sdram_ba])  err_now = ERR_CLOSED;
      end
      default: ;
    endcase
    if (!err_flag_q && err_now != ERR_NONE) begin
      err_flag_d = 1'b1;
      err_code_d = err_now;
    end
  end

  // Burst engine: a beat is produced on the command edge and on each following live edge
  always_comb begin
    bl_mask    = 3'(bl_decode(bl_code_q) - 4'd1);
    rdwr_ok    = (cmd == CMD_RD || cmd == CMD_WR) && mode_valid_q && bank_open_q[sdram_ba];
    wr_start   = rdwr_ok && (cmd == CMD_WR);
    bst_act_d  = bst_act_q;
    bst_wr_d   = bst_wr_q;
    bst_ba_d   = bst_ba_q;
    bst_row_d  = bst_row_q;
    bst_col_d  = bst_col_q;
    bst_beat_d = bst_beat_q;
    beat_go    = 1'b0;
    beat_wr    = bst_wr_q;
    beat_ba    = bst_ba_q;
    beat_row   = bst_row_q;
    beat_col   = bst_col_q;
    beat_k     = bst_beat_q;
    if (rdwr_ok) begin
      beat_go    = 1'b1;
      beat_wr    = (cmd == CMD_WR);
      beat_ba    = sdram_ba;
      beat_row   = open_row_q[sdram_ba];
      beat_col   = sdram_addr[COL_BITS-1:0];
      beat_k     = 3'd0;
      bst_act_d  = (bl_code_q != 2'd0);
      bst_wr_d   = (cmd == CMD_WR);
      bst_ba_d   = sdram_ba;
      bst_row_d  = open_row_q[sdram_ba];
      bst_col_d  = sdram_addr[COL_BITS-1:0];
      bst_beat_d = 3'd1;
    end else if (bst_act_q && sdram_cke && cmd != CMD_BST) begin
      beat_go    = 1'b1;
      bst_beat_d = bst_beat_q + 3'd1;
      if (bst_beat_q == bl_mask) bst_act_d = 1'b0;
    end
    if (cmd == CMD_BST) bst_act_d = 1'b0;
    beat_lo      = 3'(beat_col[2:0] + beat_k);
    beat_col_eff = {beat_col[COL_BITS-1:3], (beat_col[2:0] & ~bl_mask) | (beat_lo & bl_mask)};
    mem_idx      = MEM_ADDR_BITS'({beat_ba, beat_row, beat_col_eff});
    mem_we       = beat_go && beat_wr && reset_reset_n;
    pipe_flush   = !reset_reset_n || wr_start;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      mode_valid_q <= 1'b0;
      cl3_q        <= 1'b0;
      bl_code_q    <= 2'd0;
      bank_open_q  <= '0;
      open_row_q   <= '0;
      err_flag_q   <= 1'b0;
      err_code_q   <= ERR_NONE;
      bst_act_q    <= 1'b0;
      bst_wr_q     <= 1'b0;
      bst_ba_q     <= '0;
      bst_row_q    <= '0;
      bst_col_q    <= '0;
      bst_beat_q   <= 3'd0;
    end else begin
      mode_valid_q <= mode_valid_d;
      cl3_q        <= cl3_d;
      bl_code_q    <= bl_code_d;
      bank_open_q  <= bank_open_d;
      open_row_q   <= open_row_d;
      err_flag_q   <= err_flag_d;
      err_code_q   <= err_code_d;
      bst_act_q    <= bst_act_d;
      bst_wr_q     <= bst_wr_d;
      bst_ba_q     <= bst_ba_d;
      bst_row_q    <= bst_row_d;
      bst_col_q    <= bst_col_d;
      bst_beat_q   <= bst_beat_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    for (int b = 0; b < NBYTE; b++)
      if (mem_we && !sdram_dqm[b]) mem_q[mem_idx][8*b +: 8] <= sdram_dq[8*b +: 8];
  end

  sdram_rd_pipe #(.DQ_WIDTH(DQ_WIDTH)) u_rd_pipe (
    .clk       (clk_clk),
    .flush     (pipe_flush),
    .hold      (!sdram_cke),
    .cl3       (cl3_q),
    .push_vld  (beat_go && !beat_wr),
    .push_data (mem_q[mem_idx]),
    .push_oe   (~sdram_dqm),
    .out_data  (rd_data),
    .out_oe    (rd_oe)
  );

  for (genvar b = 0; b < NBYTE; b++) begin : g_dq
    assign sdram_dq[8*b +: 8] = rd_oe[b] ? rd_data[8*b +: 8] : 8'hzz;
  end

  assign mode_valid = mode_valid_q;
  assign err_flag   = err_flag_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_sdram_chip_responder.sv
// Directed bench: stimulus pushes expected dq per cycle into a queue; a monitor checks
// dq every cycle (released bus reads all-ones through the pull-up).
module tb_sdram_chip_responder;
  localparam logic [3:0] C_LMR = 4'b0000, C_REF = 4'b0001, C_PRE = 4'b0010,
                         C_ACT = 4'b0011, C_WR  = 4'b0100, C_RD  = 4'b0101,
                         C_NOP = 4'b0111;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [12:0] addr = '0;
  logic [1:0]  ba = '0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cke = 1'b1;
  logic [3:0]  dqm = '0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_dq = '0;
  tri1  [31:0] sdram_dq;
  logic        mode_valid, err_flag;
  logic [2:0]  err_code;

  assign sdram_dq = tb_oe ? tb_dq : 32'hzzzz_zzzz;

  int   cyc = 0, n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0;

  typedef struct { int c; logic [31:0] v; } exp_t;
  exp_t q[$];

  logic [31:0] wb [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_chip_responder dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sdram_addr(addr), .sdram_ba(ba),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_cke(cke), .sdram_dq(sdram_dq), .sdram_dqm(dqm),
    .mode_valid(mode_valid), .err_flag(err_flag), .err_code(err_code)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [31:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endfunction

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [31:0] d = '0, input logic oe = 1'b0,
                       input logic [3:0] m = '0, input logic ck = 1'b1);
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba = b; addr = a; tb_dq = d; tb_oe = oe; dqm = m; cke = ck;
  endtask

  task automatic nop(input int k);
    repeat (k) drive(C_NOP, 2'd0, 13'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = C_NOP; tb_oe = 1'b0; dqm = '0; cke = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the bench is not driving, dq must match the queued beat or be released
  always @(negedge clk) begin
    logic [31:0] ev;
    #1;
    if (mon_en && !tb_oe) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL dq_missed: beat %h due cyc %0d never observed (now %0d)", q[0].v, q[0].c, cyc);
        void'(q.pop_front());
      end
      ev = 32'hFFFF_FFFF;
      if (q.size() > 0 && q[0].c == cyc) begin
        ev = q[0].v;
        void'(q.pop_front());
      end
      check("dq", sdram_dq, ev);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 8; k++) wb[k] = 32'hC0DE_0000 + 32'(k * 32'h0101);

    repeat (3) @(negedge clk);
    check("rst_mode_valid", {31'd0, mode_valid}, 32'd0);
    check("rst_err_flag",   {31'd0, err_flag},   32'd0);
    check("rst_err_code",   {29'd0, err_code},   32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // READ before any LOAD MODE, then a double ACTIVE that must not overwrite the code
    drive(C_RD, 2'd0, 13'h004);
    nop(1);
    check("nomode_code", {29'd0, err_code}, 32'd3);
    check("nomode_flag", {31'd0, err_flag}, 32'd1);
    drive(C_ACT, 2'd0, 13'h010);
    drive(C_ACT, 2'd0, 13'h010);
    nop(1);
    check("sticky_code", {29'd0, err_code}, 32'd3);
    check("nomode_valid", {31'd0, mode_valid}, 32'd0);

    do_reset();
    check("rst2_err_flag", {31'd0, err_flag}, 32'd0);
    check("rst2_err_code", {29'd0, err_code}, 32'd0);

    // CL=2 BL=1 single write/read
    drive(C_LMR, 2'd0, 13'h020);
    drive(C_ACT, 2'd1, 13'h0123);
    drive(C_WR,  2'd1, 13'h004, 32'hDEADBEEF, 1'b1);
    drive(C_RD,  2'd1, 13'h004); n = cyc;
    push(n + 2, 32'hDEADBEEF);
    nop(4);
    check("t1_err_flag",   {31'd0, err_flag},   32'd0);
    check("t1_mode_valid", {31'd0, mode_valid}, 32'd1);

    // Byte-masked write, read-side DQM, and READ followed by PRECHARGE
    drive(C_WR, 2'd1, 13'h010, 32'h0000_0000, 1'b1);
    drive(C_WR, 2'd1, 13'h010, 32'hAABBCCDD, 1'b1, 4'b0101);
    drive(C_RD, 2'd1, 13'h010); n = cyc;
    push(n + 2, 32'hAA00CC00);
    nop(3);
    drive(C_RD, 2'd1, 13'h010, '0, 1'b0, 4'b1000); n = cyc;
    push(n + 2, 32'hFF00CC00);
    nop(3);
    drive(C_RD, 2'd1, 13'h010); n = cyc;
    push(n + 2, 32'hAA00CC00);
    drive(C_PRE, 2'd1, 13'h000);
    nop(3);
    drive(C_ACT, 2'd1, 13'h0123);
    check("t3_err_flag", {31'd0, err_flag}, 32'd0);

    // CL=3 BL=4 wrapped write burst at col 6, read back from col 4 and col 6
    drive(C_LMR, 2'd0, 13'h032);
    drive(C_WR,  2'd1, 13'h006, 32'h11111111, 1'b1);
    drive(C_NOP, 2'd0, 13'h000, 32'h22222222, 1'b1);
    drive(C_NOP, 2'd0, 13'h000, 32'h33333333, 1'b1);
    drive(C_NOP, 2'd0, 13'h000, 32'h44444444, 1'b1);
    drive(C_RD,  2'd1, 13'h004); n = cyc;
    push(n + 3, 32'h33333333); push(n + 4, 32'h44444444);
    push(n + 5, 32'h11111111); push(n + 6, 32'h22222222);
    nop(8);
    drive(C_RD,  2'd1, 13'h006); n = cyc;
    push(n + 3, 32'h11111111); push(n + 4, 32'h22222222);
    push(n + 5, 32'h33333333); push(n + 6, 32'h44444444);
    nop(8);

    // CL=3 BL=8: WRITE two cycles after READ cancels the read completely
    drive(C_LMR, 2'd0, 13'h033);
    drive(C_RD,  2'd1, 13'h020);
    drive(C_NOP, 2'd0, 13'h000);
    drive(C_WR,  2'd1, 13'h040, wb[0], 1'b1);
    for (int k = 1; k < 8; k++) drive(C_NOP, 2'd0, 13'h000, wb[k], 1'b1);
    nop(2);
    // Read back with cke low on the 4th and 5th edges after the READ
    drive(C_RD,  2'd1, 13'h040); n = cyc;
    push(n + 3, wb[0]); push(n + 4, wb[0]); push(n + 5, wb[0]);
    for (int k = 1; k < 8; k++) push(n + 5 + k, wb[k]);
    drive(C_NOP, 2'd0, 13'h000);
    drive(C_NOP, 2'd0, 13'h000);
    drive(C_NOP, 2'd0, 13'h000, '0, 1'b0, 4'b0000, 1'b0);
    drive(C_NOP, 2'd0, 13'h000, '0, 1'b0, 4'b0000, 1'b0);
    nop(12);
    check("t6_err_flag", {31'd0, err_flag}, 32'd0);
    check("t6_err_code", {29'd0, err_code}, 32'd0);

    // AUTO REFRESH with a bank open, then reset clears mode and banks
    drive(C_ACT, 2'd2, 13'h0055);
    drive(C_REF, 2'd0, 13'h000);
    nop(1);
    check("ref_code", {29'd0, err_code}, 32'd4);
    do_reset();
    check("rst3_err_flag",   {31'd0, err_flag},   32'd0);
    check("rst3_mode_valid", {31'd0, mode_valid}, 32'd0);
    drive(C_RD, 2'd2, 13'h000);
    nop(4);
    check("post_rst_code", {29'd0, err_code}, 32'd3);

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
